load_store_buffer: RTL and testbench

LOAD_STORE_BUFFER -- requirements
Module: load_store_buffer

---
 rtl/lsb_pkg.sv | 51 +++++
 rtl/lsb_extend.sv | 20 ++
 rtl/load_store_buffer.sv | 169 ++++++++++++++++
 tb/tb_load_store_buffer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsb_pkg.sv
// rtl/lsb_pkg.sv - shared types, funct3/width codes and operand snoop helper for the load/store buffer
package lsb_pkg;
  localparam int LSB_DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_DONE = 2'd2
  } lsb_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] value;
  } lsb_opnd_t;

  typedef struct packed {
    logic       busy;
    logic       is_store;
    logic [2:0] funct3;
    logic [4:0] rob_id;
    lsb_opnd_t  op1;
    lsb_opnd_t  op2;
    logic [31:0] imm;
  } lsb_entry_t;

  // Tag 0 means the value is already valid, so it never matches a broadcast.
  function automatic lsb_opnd_t snoop(input lsb_opnd_t o,
                                      input logic a_v, input logic [4:0] a_id, input logic [31:0] a_val,
                                      input logic b_v, input logic [4:0] b_id, input logic [31:0] b_val);
    lsb_opnd_t r;
    r = o;
    if (o.tag != 5'd0) begin
      if (a_v && a_id == o.tag) r = '{tag: 5'd0, value: a_val};
      else if (b_v && b_id == o.tag) r = '{tag: 5'd0, value: b_val};
    end
    return r;
  endfunction
endpackage

// File: rtl/lsb_extend.sv
// rtl/lsb_extend.sv - load data sign/zero extension selected by funct3
module lsb_extend
  import lsb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] value
);
  always_comb begin
    value = raw;
    case (funct3)
      LB:      value = {{24{raw[7]}}, raw[7:0]};
      LH:      value = {{16{raw[15]}}, raw[15:0]};
      LW:      value = raw;
      LBU:     value = {24'd0, raw[7:0]};
      LHU:     value = {16'd0, raw[15:0]};
      default: value = raw;
    endcase
  end
endmodule

// File: rtl/load_store_buffer.sv
// rtl/load_store_buffer.sv - in-order load/store queue with CDB snooping and single outstanding memory access
// Optional LSB_ALIGN_CHECK_EN: misaligned half/word accesses bypass memory and report on _lsb_misalign.
module load_store_buffer
  import lsb_pkg::*;
#(
  parameter int LSB_DEPTH = LSB_DEPTH_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _lsb_ready,
  input  logic        _lsb_is_store,
  input  logic [2:0]  _lsb_funct3,
  input  logic [4:0]  _lsb_rob_id,
  input  logic [4:0]  _lsb_dep_1,
  input  logic [31:0] _lsb_value_1,
  input  logic [4:0]  _lsb_dep_2,
  input  logic [31:0] _lsb_value_2,
  input  logic [31:0] _lsb_imm,
  output logic        _lsb_full,
  input  logic        _cdb_ready,
  input  logic [4:0]  _cdb_rob_id,
  input  logic [31:0] _cdb_value,
  input  logic        _store_ready,
  input  logic [4:0]  _work_rob_id,
  output logic        _mem_req,
  output logic        _mem_we,
  output logic [31:0] _mem_addr,
  output logic [31:0] _mem_wdata,
  output logic [1:0]  _mem_width,
  input  logic        _mem_done,
  input  logic [31:0] _mem_rdata,
  output logic        _cdb_ls_ready,
  output logic [4:0]  _cdb_ls_rob_id,
  output logic [31:0] _cdb_ls_value
`ifdef LSB_ALIGN_CHECK_EN
  , output logic      _lsb_misalign
`endif
);
  localparam int PW = $clog2(LSB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_AT = CW'(LSB_DEPTH - 1);
  localparam logic [CW-1:0] CAP     = CW'(LSB_DEPTH);

  lsb_entry_t    q [LSB_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  lsb_state_t    state, state_next;
  lsb_entry_t    head_e;
  logic          issue, push, pop, misalign;
  logic [31:0]   addr, ext_value;

  assign head_e = q[head];
  assign addr   = head_e.op1.value + head_e.imm;
  assign issue  = head_e.busy && head_e.op1.tag == 5'd0 && (!head_e.is_store || head_e.op2.tag == 5'd0)
                  && _store_ready && _work_rob_id == head_e.rob_id;
  assign push   = _lsb_ready && count < CAP;
  assign pop    = state == ST_DONE;
  assign _lsb_full = count >= FULL_AT;

`ifdef LSB_ALIGN_CHECK_EN
  assign misalign = (head_e.funct3[1:0] == W_HALF && addr[0]) ||
                    (head_e.funct3[1:0] == W_WORD && addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  lsb_extend u_extend (.funct3(head_e.funct3), .raw(_mem_rdata), .value(ext_value));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (issue) state_next = misalign ? ST_DONE : ST_MEM;
      ST_MEM:  if (_mem_done) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_IDLE;
    else if (rdy_in) state <= _clear ? ST_IDLE : state_next;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && _clear)) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < LSB_DEPTH; i++) q[i].busy <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < LSB_DEPTH; i++) begin
        if (q[i].busy) begin
          q[i].op1 <= snoop(q[i].op1, _cdb_ready, _cdb_rob_id, _cdb_value, _cdb_ls_ready, _cdb_ls_rob_id, _cdb_ls_value);
          q[i].op2 <= snoop(q[i].op2, _cdb_ready, _cdb_rob_id, _cdb_value, _cdb_ls_ready, _cdb_ls_rob_id, _cdb_ls_value);
        end
      end
      if (pop) begin
        q[head].busy <= 1'b0;
        head <= head + 1'b1;
      end
      // Operands broadcast in the enqueue cycle are captured here, not missed.
      if (push) begin
        q[tail] <= '{busy: 1'b1, is_store: _lsb_is_store, funct3: _lsb_funct3, rob_id: _lsb_rob_id,
                     op1: snoop(lsb_opnd_t'{tag: _lsb_dep_1, value: _lsb_value_1}, _cdb_ready, _cdb_rob_id,
                                _cdb_value, _cdb_ls_ready, _cdb_ls_rob_id, _cdb_ls_value),
                     op2: snoop(lsb_opnd_t'{tag: _lsb_dep_2, value: _lsb_value_2}, _cdb_ready, _cdb_rob_id,
                                _cdb_value, _cdb_ls_ready, _cdb_ls_rob_id, _cdb_ls_value),
                     imm: _lsb_imm};
        tail <= tail + 1'b1;
      end
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      _mem_req       <= 1'b0;
      _mem_we        <= 1'b0;
      _mem_addr      <= '0;
      _mem_wdata     <= '0;
      _mem_width     <= '0;
      _cdb_ls_ready  <= 1'b0;
      _cdb_ls_rob_id <= '0;
      _cdb_ls_value  <= '0;
`ifdef LSB_ALIGN_CHECK_EN
      _lsb_misalign  <= 1'b0;
`endif
    end else if (rdy_in) begin
      _cdb_ls_ready <= 1'b0;
`ifdef LSB_ALIGN_CHECK_EN
      _lsb_misalign <= 1'b0;
`endif
      if (_clear) begin
        _mem_req <= 1'b0;
        _mem_we  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (issue) begin
            if (misalign) begin
              _cdb_ls_ready  <= 1'b1;
              _cdb_ls_rob_id <= head_e.rob_id;
              _cdb_ls_value  <= '0;
`ifdef LSB_ALIGN_CHECK_EN
              _lsb_misalign  <= 1'b1;
`endif
            end else begin
              _mem_req   <= 1'b1;
              _mem_we    <= head_e.is_store;
              _mem_addr  <= addr;
              _mem_wdata <= head_e.op2.value;
              _mem_width <= head_e.funct3[1:0];
            end
          end
          ST_MEM: if (_mem_done) begin
            _mem_req       <= 1'b0;
            _mem_we        <= 1'b0;
            _cdb_ls_ready  <= 1'b1;
            _cdb_ls_rob_id <= head_e.rob_id;
            _cdb_ls_value  <= head_e.is_store ? 32'd0 : ext_value;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_load_store_buffer.sv
// tb/tb_load_store_buffer.sv - directed self-checking bench for load_store_buffer
module tb_load_store_buffer;
  import lsb_pkg::*;

  logic        clk_in, rst_in, rdy_in, _clear;
  logic        _lsb_ready, _lsb_is_store;
  logic [2:0]  _lsb_funct3;
  logic [4:0]  _lsb_rob_id, _lsb_dep_1, _lsb_dep_2;
  logic [31:0] _lsb_value_1, _lsb_value_2, _lsb_imm;
  logic        _lsb_full;
  logic        _cdb_ready;
  logic [4:0]  _cdb_rob_id;
  logic [31:0] _cdb_value;
  logic        _store_ready;
  logic [4:0]  _work_rob_id;
  logic        _mem_req, _mem_we, _mem_done;
  logic [31:0] _mem_addr, _mem_wdata, _mem_rdata;
  logic [1:0]  _mem_width;
  logic        _cdb_ls_ready;
  logic [4:0]  _cdb_ls_rob_id;
  logic [31:0] _cdb_ls_value;
`ifdef LSB_ALIGN_CHECK_EN
  logic        _lsb_misalign;
`endif

  int total = 0;
  int bad = 0;

  load_store_buffer #(.LSB_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
    ._lsb_ready(_lsb_ready), ._lsb_is_store(_lsb_is_store), ._lsb_funct3(_lsb_funct3),
    ._lsb_rob_id(_lsb_rob_id), ._lsb_dep_1(_lsb_dep_1), ._lsb_value_1(_lsb_value_1),
    ._lsb_dep_2(_lsb_dep_2), ._lsb_value_2(_lsb_value_2), ._lsb_imm(_lsb_imm), ._lsb_full(_lsb_full),
    ._cdb_ready(_cdb_ready), ._cdb_rob_id(_cdb_rob_id), ._cdb_value(_cdb_value),
    ._store_ready(_store_ready), ._work_rob_id(_work_rob_id),
    ._mem_req(_mem_req), ._mem_we(_mem_we), ._mem_addr(_mem_addr), ._mem_wdata(_mem_wdata),
    ._mem_width(_mem_width), ._mem_done(_mem_done), ._mem_rdata(_mem_rdata),
    ._cdb_ls_ready(_cdb_ls_ready), ._cdb_ls_rob_id(_cdb_ls_rob_id), ._cdb_ls_value(_cdb_ls_value)
`ifdef LSB_ALIGN_CHECK_EN
    , ._lsb_misalign(_lsb_misalign)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic enq(input logic st, input logic [2:0] f3, input logic [4:0] rob, input logic [4:0] d1,
                     input logic [31:0] v1, input logic [4:0] d2, input logic [31:0] v2, input logic [31:0] imm);
    _lsb_ready = 1'b1; _lsb_is_store = st; _lsb_funct3 = f3; _lsb_rob_id = rob;
    _lsb_dep_1 = d1; _lsb_value_1 = v1; _lsb_dep_2 = d2; _lsb_value_2 = v2; _lsb_imm = imm;
    tick();
    _lsb_ready = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (_mem_req === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_ls(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (_cdb_ls_ready === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic finish_mem(input logic [31:0] rdata);
    _mem_rdata = rdata; _mem_done = 1'b1;
    tick();
    _mem_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b0; _clear = 1'b1;
    tick(); tick();
    rdy_in = 1'b1; _clear = 1'b0;
    total++; if ({_mem_req, _mem_we, _cdb_ls_ready, _lsb_full} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {_mem_req, _mem_we, _cdb_ls_ready, _lsb_full}); end
    total++; if ({_mem_addr, _mem_wdata, _mem_width} !== 66'd0) begin
      bad++; $display("FAIL reset_mem got=%h/%h/%0d exp=0", _mem_addr, _mem_wdata, _mem_width); end
    total++; if ({_cdb_ls_rob_id, _cdb_ls_value} !== 37'd0) begin
      bad++; $display("FAIL reset_cdb got=%0d/%h exp=0", _cdb_ls_rob_id, _cdb_ls_value); end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_load_word();
    bit ok;
    _store_ready = 1'b1; _work_rob_id = 5'd3;
    enq(1'b0, LW, 5'd3, 5'd0, 32'h1000, 5'd0, 32'd0, 32'd4);
    wait_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL lw_req got=0 exp=1"); end
    total++; if ({_mem_addr, _mem_width, _mem_we} !== {32'h1004, 2'd2, 1'b0}) begin
      bad++; $display("FAIL lw_issue got=%h/%0d/%b exp=1004/2/0", _mem_addr, _mem_width, _mem_we); end
    tick(); tick();
    total++; if ({_mem_req, _mem_addr} !== {1'b1, 32'h1004}) begin
      bad++; $display("FAIL lw_hold got=%b/%h exp=1/1004", _mem_req, _mem_addr); end
    finish_mem(32'hDEADBEEF);
    wait_ls(ok);
    total++; if (!ok || _cdb_ls_rob_id !== 5'd3 || _cdb_ls_value !== 32'hDEADBEEF) begin
      bad++; $display("FAIL lw_result got=%b/%0d/%h exp=1/3/deadbeef", ok, _cdb_ls_rob_id, _cdb_ls_value); end
    tick();
    total++; if ({_cdb_ls_ready, _mem_req} !== 2'b00) begin
      bad++; $display("FAIL lw_one_cycle got=%b exp=00", {_cdb_ls_ready, _mem_req}); end
  endtask

  task automatic test_lb_lbu();
    bit ok;
    _work_rob_id = 5'd4;
    enq(1'b0, LB, 5'd4, 5'd0, 32'h2000, 5'd0, 32'd0, 32'd0);
    enq(1'b0, LBU, 5'd5, 5'd0, 32'h2003, 5'd0, 32'd0, 32'd0);
    wait_req(ok);
    total++; if (!ok || _mem_addr !== 32'h2000 || _mem_width !== 2'd0) begin
      bad++; $display("FAIL lb_issue got=%b/%h/%0d exp=1/2000/0", ok, _mem_addr, _mem_width); end
    finish_mem(32'h00000080);
    wait_ls(ok);
    total++; if (!ok || _cdb_ls_rob_id !== 5'd4 || _cdb_ls_value !== 32'hFFFFFF80) begin
      bad++; $display("FAIL lb_value got=%b/%0d/%h exp=1/4/ffffff80", ok, _cdb_ls_rob_id, _cdb_ls_value); end
    _work_rob_id = 5'd5;
    wait_req(ok);
    total++; if (!ok || _mem_addr !== 32'h2003) begin
      bad++; $display("FAIL lbu_issue got=%b/%h exp=1/2003", ok, _mem_addr); end
    finish_mem(32'h00000080);
    wait_ls(ok);
    total++; if (!ok || _cdb_ls_rob_id !== 5'd5 || _cdb_ls_value !== 32'h00000080) begin
      bad++; $display("FAIL lbu_value got=%b/%0d/%h exp=1/5/00000080", ok, _cdb_ls_rob_id, _cdb_ls_value); end
    tick();
  endtask

  task automatic test_store_forward();
    bit ok;
    _work_rob_id = 5'd6;
    enq(1'b1, SW, 5'd6, 5'd0, 32'h3000, 5'd5, 32'd0, 32'd8);
    tick();
    total++; if (_mem_req !== 1'b0) begin bad++; $display("FAIL sw_wait got=%b exp=0", _mem_req); end
    _cdb_ready = 1'b1; _cdb_rob_id = 5'd5; _cdb_value = 32'h12345678;
    tick();
    _cdb_ready = 1'b0;
    wait_req(ok);
    total++; if (!ok || {_mem_we, _mem_wdata, _mem_addr, _mem_width} !== {1'b1, 32'h12345678, 32'h3008, 2'd2}) begin
      bad++; $display("FAIL sw_issue got=%b/%b/%h/%h/%0d exp=1/1/12345678/3008/2", ok, _mem_we, _mem_wdata, _mem_addr, _mem_width); end
    finish_mem(32'hFFFFFFFF);
    wait_ls(ok);
    total++; if (!ok || _cdb_ls_rob_id !== 5'd6 || _cdb_ls_value !== 32'd0) begin
      bad++; $display("FAIL sw_result got=%b/%0d/%h exp=1/6/0", ok, _cdb_ls_rob_id, _cdb_ls_value); end
    tick();
  endtask

  task automatic test_enq_forward();
    bit ok;
    _work_rob_id = 5'd8;
    _cdb_ready = 1'b1; _cdb_rob_id = 5'd7; _cdb_value = 32'h4000;
    enq(1'b0, LW, 5'd8, 5'd7, 32'd0, 5'd0, 32'd0, 32'h10);
    _cdb_ready = 1'b0;
    wait_req(ok);
    total++; if (!ok || _mem_addr !== 32'h4010) begin
      bad++; $display("FAIL enq_fwd_addr got=%b/%h exp=1/4010", ok, _mem_addr); end
    finish_mem(32'h55);
    wait_ls(ok);
    total++; if (!ok || _cdb_ls_value !== 32'h55) begin
      bad++; $display("FAIL enq_fwd_value got=%b/%h exp=1/55", ok, _cdb_ls_value); end
    tick();
  endtask

  task automatic test_full_wrap();
    bit ok;
    _store_ready = 1'b0;
    for (int k = 0; k < 6; k++) enq(1'b0, LW, 5'(10 + k), 5'd0, 32'((10 + k) * 16), 5'd0, 32'd0, 32'd0);
    total++; if (_lsb_full !== 1'b0) begin bad++; $display("FAIL full_at6 got=%b exp=0", _lsb_full); end
    enq(1'b0, LW, 5'd16, 5'd0, 32'd256, 5'd0, 32'd0, 32'd0);
    total++; if (_lsb_full !== 1'b1) begin bad++; $display("FAIL full_at7 got=%b exp=1", _lsb_full); end
    _store_ready = 1'b1;
    for (int r = 10; r < 12; r++) begin
      _work_rob_id = 5'(r);
      wait_req(ok);
      finish_mem(32'(r));
      wait_ls(ok);
      tick();
      if (r == 10) begin
        total++; if (_lsb_full !== 1'b0) begin bad++; $display("FAIL full_after_pop got=%b exp=0", _lsb_full); end
      end
    end
    enq(1'b0, LW, 5'd17, 5'd0, 32'd272, 5'd0, 32'd0, 32'd0);
    enq(1'b0, LW, 5'd18, 5'd0, 32'd288, 5'd0, 32'd0, 32'd0);
    total++; if (_lsb_full !== 1'b1) begin bad++; $display("FAIL full_refill got=%b exp=1", _lsb_full); end
    for (int r = 12; r <= 18; r++) begin
      _work_rob_id = 5'(r);
      wait_req(ok);
      total++; if (!ok || _mem_addr !== 32'(r * 16)) begin
        bad++; $display("FAIL drain_addr rob=%0d got=%b/%h exp=1/%h", r, ok, _mem_addr, 32'(r * 16)); end
      finish_mem(32'(r));
      wait_ls(ok);
      total++; if (!ok || _cdb_ls_rob_id !== 5'(r) || _cdb_ls_value !== 32'(r)) begin
        bad++; $display("FAIL drain_result got=%b/%0d/%h exp=1/%0d/%h", ok, _cdb_ls_rob_id, _cdb_ls_value, r, r); end
      tick();
    end
  endtask

  task automatic test_clear();
    bit ok;
    _store_ready = 1'b1; _work_rob_id = 5'd21;
    for (int k = 0; k < 4; k++) enq(1'b0, LW, 5'(21 + k), 5'd0, 32'h7000, 5'd0, 32'd0, 32'd0);
    total++; if (_mem_req !== 1'b1) begin bad++; $display("FAIL clr_pre_req got=%b exp=1", _mem_req); end
    _clear = 1'b1;
    enq(1'b0, LW, 5'd25, 5'd0, 32'h7100, 5'd0, 32'd0, 32'd0);
    _clear = 1'b0;
    total++; if ({_mem_req, _lsb_full, _cdb_ls_ready} !== 3'b000) begin
      bad++; $display("FAIL clr_state got=%b exp=000", {_mem_req, _lsb_full, _cdb_ls_ready}); end
    ok = 1'b0;
    _work_rob_id = 5'd25;
    for (int i = 0; i < 3; i++) begin tick(); if (_mem_req) ok = 1'b1; end
    _work_rob_id = 5'd21;
    for (int i = 0; i < 3; i++) begin tick(); if (_mem_req) ok = 1'b1; end
    total++; if (ok) begin bad++; $display("FAIL clr_no_req got=1 exp=0"); end
    _store_ready = 1'b0;
    for (int k = 0; k < 6; k++) enq(1'b0, LW, 5'(1 + k), 5'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    total++; if (_lsb_full !== 1'b0) begin bad++; $display("FAIL clr_count got=%b exp=0", _lsb_full); end
    _clear = 1'b1; tick(); _clear = 1'b0;
  endtask

  task automatic test_rdy_hold();
    bit ok;
    _store_ready = 1'b1; _work_rob_id = 5'd26;
    enq(1'b0, LW, 5'd26, 5'd0, 32'h5000, 5'd0, 32'd0, 32'd0);
    wait_req(ok);
    rdy_in = 1'b0; _mem_rdata = 32'hCAFEF00D; _mem_done = 1'b1;
    tick(); tick();
    total++; if (!ok || {_mem_req, _cdb_ls_ready} !== 2'b10) begin
      bad++; $display("FAIL rdy_hold got=%b/%b exp=1/10", ok, {_mem_req, _cdb_ls_ready}); end
    rdy_in = 1'b1;
    tick();
    _mem_done = 1'b0;
    total++; if ({_cdb_ls_ready, _cdb_ls_value} !== {1'b1, 32'hCAFEF00D}) begin
      bad++; $display("FAIL rdy_resume got=%b/%h exp=1/cafef00d", _cdb_ls_ready, _cdb_ls_value); end
    tick();
  endtask

  task automatic test_reset_abort();
    bit ok;
    _work_rob_id = 5'd27;
    enq(1'b0, LW, 5'd27, 5'd0, 32'h6000, 5'd0, 32'd0, 32'd0);
    wait_req(ok);
    rst_in = 1'b1; rdy_in = 1'b0;
    tick();
    rst_in = 1'b0; rdy_in = 1'b1;
    total++; if (!ok || _mem_req !== 1'b0 || _mem_addr !== 32'd0) begin
      bad++; $display("FAIL rst_abort got=%b/%b/%h exp=1/0/0", ok, _mem_req, _mem_addr); end
    tick(); tick(); tick();
    total++; if (_mem_req !== 1'b0) begin bad++; $display("FAIL rst_empty got=%b exp=0", _mem_req); end
  endtask

  task automatic test_misalign();
    bit ok;
`ifdef LSB_ALIGN_CHECK_EN
    bit seen;
    _store_ready = 1'b1; _work_rob_id = 5'd9;
    enq(1'b0, LH, 5'd9, 5'd0, 32'h1001, 5'd0, 32'd0, 32'd0);
    seen = 1'b0; ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (_mem_req) seen = 1'b1;
      if (_cdb_ls_ready) ok = 1'b1; else tick();
    end
    total++; if (!ok || seen || {_lsb_misalign, _cdb_ls_rob_id, _cdb_ls_value} !== {1'b1, 5'd9, 32'd0}) begin
      bad++; $display("FAIL misalign got=%b/%b/%b/%0d/%h exp=1/0/1/9/0", ok, seen, _lsb_misalign, _cdb_ls_rob_id, _cdb_ls_value); end
    tick();
    total++; if ({_lsb_misalign, _cdb_ls_ready} !== 2'b00) begin
      bad++; $display("FAIL misalign_clear got=%b exp=00", {_lsb_misalign, _cdb_ls_ready}); end
`else
    _store_ready = 1'b1; _work_rob_id = 5'd9;
    enq(1'b0, LH, 5'd9, 5'd0, 32'h1001, 5'd0, 32'd0, 32'd0);
    wait_req(ok);
    total++; if (!ok || _mem_addr !== 32'h1001 || _mem_width !== 2'd1) begin
      bad++; $display("FAIL lh_unaligned_issue got=%b/%h/%0d exp=1/1001/1", ok, _mem_addr, _mem_width); end
    finish_mem(32'h00008001);
    wait_ls(ok);
    total++; if (!ok || _cdb_ls_value !== 32'hFFFF8001) begin
      bad++; $display("FAIL lh_value got=%b/%h exp=1/ffff8001", ok, _cdb_ls_value); end
    tick();
`endif
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0;
    _lsb_ready = 1'b0; _lsb_is_store = 1'b0; _lsb_funct3 = 3'd0; _lsb_rob_id = 5'd0;
    _lsb_dep_1 = 5'd0; _lsb_value_1 = 32'd0; _lsb_dep_2 = 5'd0; _lsb_value_2 = 32'd0; _lsb_imm = 32'd0;
    _cdb_ready = 1'b0; _cdb_rob_id = 5'd0; _cdb_value = 32'd0;
    _store_ready = 1'b0; _work_rob_id = 5'd0;
    _mem_done = 1'b0; _mem_rdata = 32'd0;
    test_reset();
    test_load_word();
    test_lb_lbu();
    test_store_forward();
    test_enq_forward();
    test_full_wrap();
    test_clear();
    test_rdy_hold();
    test_reset_abort();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
